// File: rtl/fifo_rd_sched_pkg.sv
// Shared definitions for the FIFO read-side scheduler: state encoding and channel indices.
package fifo_rd_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BURST = 2'd1;
  localparam state_t ST_TAIL  = 2'd2;
  localparam state_t ST_COOL  = 2'd3;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fifo_rd_sched_if.sv
// Consumer-side and FIFO read-port signals of the read scheduler, bundled as one interface.
interface fifo_rd_sched_if #(
  parameter int unsigned KUAN    = 16,
  parameter int unsigned SHENBIT = 11
);
  logic [1:0]         req;
  logic [1:0]         gnt;
  logic [KUAN-1:0]    dout;
  logic               dvalid;
  logic               dlast;
  logic               dch;
  logic               busy;
  logic               rdreq;
  logic [KUAN-1:0]    q;
  logic               rdempty;
  logic [SHENBIT-1:0] rdusedw;

  modport master (
    input  req, q, rdempty, rdusedw,
    output gnt, dout, dvalid, dlast, dch, busy, rdreq
  );

  modport slave (
    output req, q, rdempty, rdusedw,
    input  gnt, dout, dvalid, dlast, dch, busy, rdreq
  );
endinterface

// File: rtl/fifo_rd_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner on each accept strobe.
module rr_arb2
  import fifo_rd_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_idx
);

  logic r_ptr;
  logic w_idx;

  always_comb begin
    w_idx = r_ptr;
    if (!i_req[r_ptr]) w_idx = ~r_ptr;
  end

  assign o_idx = w_idx;
  assign o_gnt = (|i_req) ? ch_onehot(w_idx) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= CH0;
    end else if (i_accept) begin
      r_ptr <= ~w_idx;
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-domain scheduler sharing one FIFO read port between two consumers with
// fixed-length bursts and a timeout-driven partial flush.
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int unsigned KUAN    = 16,
  parameter int unsigned SHENBIT = 11,
  parameter int unsigned BURST   = 16,
  parameter int unsigned TMO     = 255
) (
  input logic             rdclk,
  input logic             sclr,
  fifo_rd_sched_if.master bus
);

  localparam int unsigned        TW      = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TW-1:0]      TMO_V   = TW'(TMO);
  localparam logic [SHENBIT-1:0] BURST_V = SHENBIT'(BURST);
  localparam logic [SHENBIT-1:0] ONE_V   = SHENBIT'(1);

  state_t             r_state;
  logic               r_cool;
  logic [SHENBIT-1:0] r_cnt;
  logic [TW-1:0]      r_tmo;
  logic               r_rdreq;
  logic               r_dvalid;
  logic               r_dlast;
  logic               r_dch;
  logic [1:0]         r_gnt;

  logic               w_any;
  logic               w_full;
  logic               w_low;
  logic               w_part;
  logic               w_start;
  logic               w_rdlast;
  logic [SHENBIT-1:0] w_n;
  logic [1:0]         w_arb_gnt;
  logic               w_arb_idx;
  logic [KUAN-1:0]    w_dout;

  assign w_any    = |bus.req;
  assign w_full   = (bus.rdusedw >= BURST_V);
  assign w_low    = (bus.rdusedw != '0) && (bus.rdusedw < BURST_V);
  assign w_part   = (TMO != 0) && w_low && (r_tmo == TMO_V);
  assign w_start  = (r_state == ST_IDLE) && w_any && !bus.rdempty && (w_full || w_part);
  assign w_n      = w_full ? BURST_V : bus.rdusedw;
  assign w_rdlast = r_rdreq && (r_cnt == ONE_V);

  rr_arb2 u_arb (
    .clk      (rdclk),
    .rst      (sclr),
    .i_req    (bus.req),
    .i_accept (w_start),
    .o_gnt    (w_arb_gnt),
    .o_idx    (w_arb_idx)
  );

  always_ff @(posedge rdclk) begin
    if (sclr) begin
      r_state  <= ST_IDLE;
      r_cool   <= 1'b0;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_rdreq  <= 1'b0;
      r_dvalid <= 1'b0;
      r_dlast  <= 1'b0;
      r_dch    <= CH0;
      r_gnt    <= '0;
    end else begin
      r_dvalid <= r_rdreq;
      r_dlast  <= w_rdlast;

      if (w_start || !w_any || (bus.rdusedw == '0)) begin
        r_tmo <= '0;
      end else if ((r_state == ST_IDLE) && w_low && (r_tmo != TMO_V)) begin
        r_tmo <= r_tmo + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_BURST;
            r_rdreq <= 1'b1;
            r_cnt   <= w_n;
            r_gnt   <= w_arb_gnt;
            r_dch   <= w_arb_idx;
          end
        end
        ST_BURST: begin
          // r_cnt holds the reads still outstanding including the current one
          r_cnt <= r_cnt - ONE_V;
          if (r_cnt == ONE_V) begin
            r_rdreq <= 1'b0;
            r_state <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          r_gnt   <= '0;
          r_cool  <= 1'b0;
          r_state <= ST_COOL;
        end
        ST_COOL: begin
          if (r_cool) r_state <= ST_IDLE;
          else        r_cool  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // q is already registered inside the FIFO, so it lines up with the delayed valid
  assign w_dout = r_dvalid ? bus.q : '0;

  assign bus.dout   = w_dout;
  assign bus.dvalid = r_dvalid;
  assign bus.dlast  = r_dlast;
  assign bus.dch    = r_dch;
  assign bus.gnt    = r_gnt;
  assign bus.rdreq  = r_rdreq;
  assign bus.busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Scoreboard bench for fifo_rd_sched against a behavioural FIFO read port.
module tb_fifo_rd_sched;

  localparam int unsigned KUAN    = 16;
  localparam int unsigned SHENBIT = 11;
  localparam int unsigned BURST   = 16;
  localparam int unsigned TMO     = 8;

  typedef struct packed {
    logic [KUAN-1:0] d;
    logic            ch;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic sclr;
  always #5 clk = ~clk;

  fifo_rd_sched_if #(.KUAN(KUAN), .SHENBIT(SHENBIT)) bus ();
  fifo_rd_sched_if #(.KUAN(KUAN), .SHENBIT(SHENBIT)) bus0 ();

  fifo_rd_sched #(.KUAN(KUAN), .SHENBIT(SHENBIT), .BURST(BURST), .TMO(TMO)) dut (
    .rdclk (clk),
    .sclr  (sclr),
    .bus   (bus)
  );

  fifo_rd_sched #(.KUAN(KUAN), .SHENBIT(SHENBIT), .BURST(BURST), .TMO(0)) dut0 (
    .rdclk (clk),
    .sclr  (sclr),
    .bus   (bus0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural FIFO read port: registered q, fill count straight from the pointers
  logic [KUAN-1:0]    mem [0:1023];
  logic [SHENBIT-1:0] wptr, rptr;
  logic               wr_en, flush;
  logic [KUAN-1:0]    wr_data;
  int                 n_uflow = 0;

  assign bus.rdusedw = wptr - rptr;
  assign bus.rdempty = (wptr == rptr);

  always @(posedge clk) begin
    if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[9:0]] <= wr_data;
        wptr <= wptr + 1'b1;
      end
      if (bus.rdreq) begin
        if (wptr == rptr) n_uflow <= n_uflow + 1;
        bus.q <= mem[rptr[9:0]];
        rptr  <= rptr + 1'b1;
      end
    end
  end

  exp_t sb[$];
  exp_t e_mon;
  bit   mon_en = 0;
  logic prev_rdreq = 1'b0;
  logic prev_sclr = 1'b0;
  bit   seen_rd = 0;
  int   n_rd = 0;
  int   n_dv = 0;
  int   idle_run = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!prev_sclr) check("dvalid_lag", bus.dvalid, prev_rdreq);
      if (bus.dvalid) begin
        n_dv++;
        if (sb.size() == 0) begin
          check("unexpected_dvalid", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check("dout", bus.dout, e_mon.d);
          check("dch", bus.dch, e_mon.ch);
          check("dlast", bus.dlast, e_mon.last);
          check("gnt", bus.gnt, e_mon.ch ? 32'd2 : 32'd1);
        end
      end
      if (bus.rdreq) begin
        n_rd++;
        check("busy", bus.busy, 1);
        if (!prev_rdreq && seen_rd) check("gap", idle_run >= 4, 1);
        seen_rd  = 1;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      prev_rdreq = bus.rdreq;
      prev_sclr  = sclr;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    sclr    = 1'b1;
    flush   = 1'b1;
    bus.req = 2'b00;
    tick(2);
    sclr  = 1'b0;
    flush = 1'b0;
    sb.delete();
    tick(1);
  endtask

  task automatic load(input int n, input int base);
    wr_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = KUAN'(base + i);
      tick(1);
    end
    wr_en = 1'b0;
  endtask

  task automatic expect_burst(input int base, input int n, input logic ch, input bit with_last);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d    = KUAN'(base + i);
      e.ch   = ch;
      e.last = with_last && (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_rd(input string tag, input int max);
    int c = 0;
    while (!bus.rdreq && c < max) begin
      tick(1);
      c++;
    end
    check(tag, bus.rdreq, 1);
  endtask

  task automatic drain(input string tag, input int max);
    int c = 0;
    while (sb.size() != 0 && c < max) begin
      tick(1);
      c++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k, c, hits;

    sclr = 1'b1; flush = 1'b1; wr_en = 1'b0; wr_data = '0; bus.req = 2'b00;
    bus0.req = 2'b00; bus0.rdusedw = '0; bus0.rdempty = 1'b1; bus0.q = '0;
    tick(3);
    sclr = 1'b0; flush = 1'b0;
    #1;

    check("rst_gnt", bus.gnt, 0);
    check("rst_rdreq", bus.rdreq, 0);
    check("rst_dvalid", bus.dvalid, 0);
    check("rst_dlast", bus.dlast, 0);
    check("rst_dch", bus.dch, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst0_rdreq", bus0.rdreq, 0);
    mon_en = 1;

    // Full burst to ch0
    do_reset();
    load(20, 'h100);
    expect_burst('h100, 16, 1'b0, 1'b1);
    n_rd = 0; n_dv = 0;
    bus.req = 2'b01;
    wait_rd("t1_start", 10);
    check("t1_gnt", bus.gnt, 1);
    bus.req = 2'b00;
    drain("t1_drain", 40);
    check("t1_nrd", n_rd, 16);
    check("t1_ndv", n_dv, 16);

    // Alternating bursts with both requests held
    do_reset();
    load(48, 'h200);
    expect_burst('h200, 16, 1'b0, 1'b1);
    expect_burst('h210, 16, 1'b1, 1'b1);
    expect_burst('h220, 16, 1'b0, 1'b1);
    n_rd = 0;
    bus.req = 2'b11;
    drain("t2_drain", 200);
    check("t2_nrd", n_rd, 48);
    bus.req = 2'b00;

    // Timeout-driven partial burst to ch1
    do_reset();
    load(5, 'h300);
    expect_burst('h300, 5, 1'b1, 1'b1);
    n_rd = 0;
    bus.req = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t3_quiet", bus.rdreq, 0);
    end
    wait_rd("t3_start", 20);
    check("t3_gnt", bus.gnt, 2);
    drain("t3_drain", 40);
    check("t3_nrd", n_rd, 5);
    bus.req = 2'b00;

    // TMO=0 never issues partial bursts
    bus0.rdusedw = SHENBIT'(5); bus0.rdempty = 1'b0; bus0.req = 2'b01;
    hits = 0;
    repeat (1000) begin
      tick(1);
      if (bus0.rdreq) hits++;
    end
    check("t4_no_rd", hits, 0);
    check("t4_busy", bus0.busy, 0);
    bus0.req = 2'b00;

    // Reset on the 7th read of a burst
    do_reset();
    load(20, 'h500);
    expect_burst('h500, 6, 1'b0, 1'b0);
    bus.req = 2'b01;
    k = 0; c = 0;
    while (k < 7 && c < 50) begin
      tick(1);
      if (bus.rdreq) k++;
      c++;
    end
    check("t5_k", k, 7);
    sclr = 1'b1;
    bus.req = 2'b00;
    tick(1);
    check("t5_rdreq", bus.rdreq, 0);
    check("t5_gnt", bus.gnt, 0);
    check("t5_dvalid", bus.dvalid, 0);
    sclr = 1'b0;
    check("t5_sb", sb.size(), 0);
    sb.delete();
    load(16, 'h600);
    for (int i = 0; i < 16; i++) begin
      e.d    = (i < 13) ? KUAN'('h507 + i) : KUAN'('h600 + i - 13);
      e.ch   = 1'b0;
      e.last = (i == 15);
      sb.push_back(e);
    end
    bus.req = 2'b11;
    wait_rd("t5_restart", 10);
    check("t5_gnt_ch0", bus.gnt, 1);
    bus.req = 2'b00;
    drain("t5_drain", 40);

    // Request dropped mid-burst
    do_reset();
    load(16, 'h700);
    expect_burst('h700, 16, 1'b0, 1'b1);
    n_rd = 0;
    bus.req = 2'b01;
    wait_rd("t6_start", 10);
    tick(2);
    bus.req = 2'b00;
    drain("t6_drain", 40);
    check("t6_nrd", n_rd, 16);

    tick(5);
    check("uflow", n_uflow, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
